// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a multiplexed 7-segment display: digit select, hex decode, PWM, dead time.
// Optional decimal-point lane enabled by defining SEG_DP_EN (adds wr_dp input).
module seg_scan_ctrl #(
    parameter int DIGITS        = 2,
    parameter int SCAN_DIV_BITS = 11,
    parameter int PWM_BITS      = 3
) (
    input  logic                  clk_50M,
    input  logic                  rst_button,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_blank,
`ifdef SEG_DP_EN
    input  logic [DIGITS-1:0]     wr_dp,
`endif
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [7:0]            digit_seg,
    output logic [DIGITS-1:0]     digit_cath,
    output logic                  frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]         IDX_ONE  = IDX_W'(1);
    localparam logic [SCAN_DIV_BITS-1:0] PRE_ONE  = SCAN_DIV_BITS'(1);

    function automatic logic [7:0] hex2seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hFC;
            4'h1: s = 8'h60;
            4'h2: s = 8'hDA;
            4'h3: s = 8'hF2;
            4'h4: s = 8'h66;
            4'h5: s = 8'hB6;
            4'h6: s = 8'hBE;
            4'h7: s = 8'hE0;
            4'h8: s = 8'hFE;
            4'h9: s = 8'hF6;
            4'hA: s = 8'hEE;
            4'hB: s = 8'h3E;
            4'hC: s = 8'h9C;
            4'hD: s = 8'h7A;
            4'hE: s = 8'h9E;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    logic [SCAN_DIV_BITS-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [DIGITS-1:0][3:0]      act_nib_q, act_nib_d;
    logic [DIGITS-1:0][3:0]      shd_nib_q, shd_nib_d;
    logic [DIGITS-1:0]           act_blank_q, act_blank_d;
    logic [DIGITS-1:0]           shd_blank_q, shd_blank_d;
    logic                        pend_q, pend_d;
    logic [7:0]                  seg_q, seg_d;
    logic [DIGITS-1:0]           cath_q, cath_d;
    logic                        fs_q, fs_d;

    logic                        tick;
    logic                        boundary;
    logic                        accept;
    logic                        commit;
    logic                        lit;
    logic                        dp_bit;
    logic [PWM_BITS-1:0]         pwm_slice;
    logic [7:0]                  dec;

`ifdef SEG_DP_EN
    logic [DIGITS-1:0]           act_dp_q, act_dp_d;
    logic [DIGITS-1:0]           shd_dp_q, shd_dp_d;
`endif

    always_comb begin
        tick      = &presc_q;
        boundary  = tick && (idx_q == IDX_LAST);
        accept    = wr_valid && !pend_q;
        commit    = boundary && pend_q;
        pwm_slice = presc_q[SCAN_DIV_BITS-1 -: PWM_BITS];
        // Slot position 0 is the dead time that hides ghosting between digits
        lit       = (presc_q != '0) && (pwm_slice <= brightness)
                    && !act_blank_q[idx_q];
        dec       = hex2seg(act_nib_q[idx_q]);
`ifdef SEG_DP_EN
        dp_bit    = act_dp_q[idx_q];
`else
        dp_bit    = 1'b0;
`endif
    end

    always_comb begin
        presc_d     = presc_q + PRE_ONE;
        idx_d       = idx_q;
        act_nib_d   = act_nib_q;
        act_blank_d = act_blank_q;
        shd_nib_d   = shd_nib_q;
        shd_blank_d = shd_blank_q;
        pend_d      = pend_q;
        seg_d       = 8'h00;
        cath_d      = '0;
        fs_d        = boundary;
`ifdef SEG_DP_EN
        act_dp_d    = act_dp_q;
        shd_dp_d    = shd_dp_q;
`endif
        if (tick) begin
            idx_d = boundary ? '0 : idx_q + IDX_ONE;
        end
        if (commit) begin
            act_nib_d   = shd_nib_q;
            act_blank_d = shd_blank_q;
            pend_d      = 1'b0;
`ifdef SEG_DP_EN
            act_dp_d    = shd_dp_q;
`endif
        end
        // accept needs !pend_q, so it never collides with a commit
        if (accept) begin
            shd_nib_d   = wr_data;
            shd_blank_d = wr_blank;
            pend_d      = 1'b1;
`ifdef SEG_DP_EN
            shd_dp_d    = wr_dp;
`endif
        end
        if (lit) begin
            seg_d         = {dec[7:1], dp_bit};
            cath_d[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_50M or posedge rst_button) begin
        if (rst_button) begin
            presc_q     <= '0;
            idx_q       <= '0;
            act_nib_q   <= '0;
            act_blank_q <= '1;
            shd_nib_q   <= '0;
            shd_blank_q <= '1;
            pend_q      <= 1'b0;
            seg_q       <= 8'h00;
            cath_q      <= '0;
            fs_q        <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            act_nib_q   <= act_nib_d;
            act_blank_q <= act_blank_d;
            shd_nib_q   <= shd_nib_d;
            shd_blank_q <= shd_blank_d;
            pend_q      <= pend_d;
            seg_q       <= seg_d;
            cath_q      <= cath_d;
            fs_q        <= fs_d;
        end
    end

`ifdef SEG_DP_EN
    always_ff @(posedge clk_50M or posedge rst_button) begin
        if (rst_button) begin
            act_dp_q <= '0;
            shd_dp_q <= '0;
        end else begin
            act_dp_q <= act_dp_d;
            shd_dp_q <= shd_dp_d;
        end
    end
`endif

    assign wr_ready    = ~pend_q;
    assign digit_seg   = seg_q;
    assign digit_cath  = cath_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-count reference model plus directed frame checks.
// Small geometry: 2 digits, 16-cycle slots, 3-bit brightness.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic [1:0] wr_blank;
    logic [2:0] brightness;
    logic [7:0] digit_seg;
    logic [1:0] digit_cath;
    logic       frame_start;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    localparam logic [7:0] SEG_TBL [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    seg_scan_ctrl #(
        .DIGITS(2),
        .SCAN_DIV_BITS(4),
        .PWM_BITS(3)
    ) dut (
        .clk_50M(clk),
        .rst_button(rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .wr_blank(wr_blank),
        .brightness(brightness),
        .digit_seg(digit_seg),
        .digit_cath(digit_cath),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: slot position and digit come straight from the cycle count
    int         cyc;
    logic [3:0] m_act [2];
    logic [3:0] m_shd [2];
    logic [1:0] m_blank;
    logic [1:0] m_shd_blank;
    logic       m_pend;
    logic [7:0] e_seg;
    logic [1:0] e_cath;
    logic       e_fs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0;
            m_act[0] = 4'h0; m_act[1] = 4'h0;
            m_shd[0] = 4'h0; m_shd[1] = 4'h0;
            m_blank = 2'b11; m_shd_blank = 2'b11;
            m_pend = 1'b0;
            e_seg = 8'h00; e_cath = 2'b00; e_fs = 1'b0;
        end else begin
            int  p, d;
            bit  on, bnd, old_pend;
            p   = cyc % 16;
            d   = (cyc / 16) % 2;
            on  = (p != 0) && ((p / 2) <= int'(brightness)) && !m_blank[d];
            e_seg  = on ? SEG_TBL[m_act[d]] : 8'h00;
            e_cath = on ? 2'(1 << d) : 2'b00;
            bnd = (cyc % 32) == 31;
            e_fs = bnd;
            old_pend = m_pend;
            if (bnd && old_pend) begin
                m_act[0] = m_shd[0]; m_act[1] = m_shd[1];
                m_blank = m_shd_blank;
                m_pend = 1'b0;
            end
            if (wr_valid && !old_pend) begin
                m_shd[0] = wr_data[3:0]; m_shd[1] = wr_data[7:4];
                m_shd_blank = wr_blank;
                m_pend = 1'b1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_seg", {24'h0, digit_seg}, {24'h0, e_seg});
            check("model_cath", {30'h0, digit_cath}, {30'h0, e_cath});
            check("model_fs", {31'h0, frame_start}, {31'h0, e_fs});
            check("model_ready", {31'h0, wr_ready}, {31'h0, ~m_pend});
        end
    end

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (frame_start) begin
                seen = 1'b1;
                break;
            end
        end
        check("frame_timeout", {31'h0, seen}, 32'h1);
    endtask

    task automatic load(input logic [7:0] d, input logic [1:0] b);
        bit ok = 1'b0;
        wr_data  = d;
        wr_blank = b;
        wr_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (wr_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("load_timeout", {31'h0, ok}, 32'h1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Observes one whole frame starting right after a frame_start sample
    task automatic scan_frame(output int c0, output int c1,
                              output logic [7:0] s0, output logic [7:0] s1);
        c0 = 0; c1 = 0; s0 = 8'h00; s1 = 8'h00;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (digit_cath == 2'b01) begin
                c0++;
                s0 = digit_seg;
            end else if (digit_cath == 2'b10) begin
                c1++;
                s1 = digit_seg;
            end
        end
        check("frame_wrap", {31'h0, frame_start}, 32'h1);
    endtask

    initial begin
        int c0, c1;
        logic [7:0] s0, s1;
        rst = 1'b0;
        wr_valid = 1'b0;
        wr_data = 8'h00;
        wr_blank = 2'b00;
        brightness = 3'd7;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        repeat (40) @(negedge clk);
        check("idle_seg", {24'h0, digit_seg}, 32'h00);
        check("idle_cath", {30'h0, digit_cath}, 32'h0);
        check("idle_ready", {31'h0, wr_ready}, 32'h1);

        wait_frame();
        load(8'hA5, 2'b00);
        check("pend_ready", {31'h0, wr_ready}, 32'h0);
        wait_frame();
        check("commit_ready", {31'h0, wr_ready}, 32'h1);
        scan_frame(c0, c1, s0, s1);
        check("a5_cnt0", c0, 15);
        check("a5_cnt1", c1, 15);
        check("a5_seg0", {24'h0, s0}, 32'hB6);
        check("a5_seg1", {24'h0, s1}, 32'hEE);

        load(8'hA5, 2'b00);
        check("stall_ready", {31'h0, wr_ready}, 32'h0);
        load(8'h3C, 2'b00);
        check("second_pend", {31'h0, wr_ready}, 32'h0);
        wait_frame();
        scan_frame(c0, c1, s0, s1);
        check("3c_seg0", {24'h0, s0}, 32'h9C);
        check("3c_seg1", {24'h0, s1}, 32'hF2);

        brightness = 3'd0;
        scan_frame(c0, c1, s0, s1);
        check("b0_cnt0", c0, 1);
        check("b0_cnt1", c1, 1);
        brightness = 3'd3;
        scan_frame(c0, c1, s0, s1);
        check("b3_cnt0", c0, 7);
        check("b3_cnt1", c1, 7);

        load(8'h12, 2'b10);
        wait_frame();
        scan_frame(c0, c1, s0, s1);
        check("blank_cnt0", c0, 7);
        check("blank_seg0", {24'h0, s0}, 32'hDA);
        check("blank_cnt1", c1, 0);

        brightness = 3'd7;
        load(8'h77, 2'b00);
        check("rst_pre_pend", {31'h0, wr_ready}, 32'h0);
        #3 rst = 1'b1;
        #1;
        check("rst_seg", {24'h0, digit_seg}, 32'h00);
        check("rst_cath", {30'h0, digit_cath}, 32'h0);
        check("rst_ready", {31'h0, wr_ready}, 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_frame();
        scan_frame(c0, c1, s0, s1);
        check("lost_cnt0", c0, 0);
        check("lost_cnt1", c1, 0);
        check("lost_ready", {31'h0, wr_ready}, 32'h1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
